// File: rtl/bg_region_map.sv
// bg_region_map: maps pixel coordinates to a prioritised screen region and its memory address
module bg_region_map #(
  parameter int NUM_REGIONS = 4,
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 19
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_region,
  input  logic [2:0]         cfg_field,
  input  logic [ADDR_W-1:0]  cfg_data,
  output logic               cfg_ack,
  output logic               cfg_err,
  output logic               out_valid,
  output logic [2:0]         region_id,
  output logic [ADDR_W-1:0]  read_address
);

  function automatic logic [COORD_W-1:0] dflt(int k, int f);
    int v;
    v = f == 0 ? ((k == 1 || k == 2) ? 320 : 0) :
        f == 1 ? (k == 2 ? 240 : 0) :
        f == 2 ? (k < 3 ? 320 : 0) :
                 (k == 0 ? 480 : (k < 3 ? 240 : 0));
    return COORD_W'(v);
  endfunction

  logic [COORD_W-1:0] x0_r [NUM_REGIONS];
  logic [COORD_W-1:0] y0_r [NUM_REGIONS];
  logic [COORD_W-1:0] w_r  [NUM_REGIONS];
  logic [COORD_W-1:0] h_r  [NUM_REGIONS];
  logic [ADDR_W-1:0]  base_r [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_r;

  logic cfg_ok;
  assign cfg_ok = ({1'b0, cfg_region} < 4'(NUM_REGIONS)) && (cfg_field <= 3'd5);

  // region registers: written only by legal config writes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        x0_r[k]   <= dflt(k, 0);
        y0_r[k]   <= dflt(k, 1);
        w_r[k]    <= dflt(k, 2);
        h_r[k]    <= dflt(k, 3);
        base_r[k] <= '0;
        en_r[k]   <= k < 3;
      end
    end else if (cfg_we && cfg_ok) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        if (cfg_region == 3'(k)) begin
          if (cfg_field == 3'd0) x0_r[k] <= cfg_data[COORD_W-1:0];
          if (cfg_field == 3'd1) y0_r[k] <= cfg_data[COORD_W-1:0];
          if (cfg_field == 3'd2) w_r[k] <= cfg_data[COORD_W-1:0];
          if (cfg_field == 3'd3) h_r[k] <= cfg_data[COORD_W-1:0];
          if (cfg_field == 3'd4) base_r[k] <= cfg_data;
          if (cfg_field == 3'd5) en_r[k] <= cfg_data[0];
        end
      end
    end
  end

  // write response pulses, one cycle after the strobe
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_we && cfg_ok;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  logic [NUM_REGIONS-1:0] hit_c;
  logic [COORD_W-1:0] offx_c [NUM_REGIONS];
  logic [COORD_W-1:0] offy_c [NUM_REGIONS];

  // per-region half-open hit test at COORD_W+1 bits so x0+w cannot wrap
  always_comb begin
    hit_c  = '0;
    offx_c = '{default: '0};
    offy_c = '{default: '0};
    for (int k = 0; k < NUM_REGIONS; k++) begin
      hit_c[k] = pix_valid && en_r[k] &&
                 (DrawX >= x0_r[k]) && ({1'b0, DrawX} < {1'b0, x0_r[k]} + {1'b0, w_r[k]}) &&
                 (DrawY >= y0_r[k]) && ({1'b0, DrawY} < {1'b0, y0_r[k]} + {1'b0, h_r[k]});
      offx_c[k] = DrawX - x0_r[k];
      offy_c[k] = DrawY - y0_r[k];
    end
  end

  logic                   s1_valid;
  logic [NUM_REGIONS-1:0] s1_match;
  logic [COORD_W-1:0]     s1_offx [NUM_REGIONS];
  logic [COORD_W-1:0]     s1_offy [NUM_REGIONS];
  logic [COORD_W-1:0]     s1_w    [NUM_REGIONS];
  logic [ADDR_W-1:0]      s1_base [NUM_REGIONS];

  // stage 1 snapshots w and base too, so a later config write cannot alter an in-flight pixel
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
      for (int k = 0; k < NUM_REGIONS; k++) begin
        s1_offx[k] <= '0;
        s1_offy[k] <= '0;
        s1_w[k]    <= '0;
        s1_base[k] <= '0;
      end
    end else begin
      s1_valid <= pix_valid;
      s1_match <= hit_c;
      for (int k = 0; k < NUM_REGIONS; k++) begin
        s1_offx[k] <= offx_c[k];
        s1_offy[k] <= offy_c[k];
        s1_w[k]    <= w_r[k];
        s1_base[k] <= base_r[k];
      end
    end
  end

  logic [2:0]        id_c;
  logic [ADDR_W-1:0] addr_c;

  // priority encode: scanning downward leaves the lowest matching index in place
  always_comb begin
    id_c   = '0;
    addr_c = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (s1_match[k]) begin
        id_c   = 3'(k + 1);
        addr_c = s1_base[k] + ADDR_W'(s1_offx[k]) +
                 ADDR_W'({{COORD_W{1'b0}}, s1_offy[k]} * {{COORD_W{1'b0}}, s1_w[k]});
      end
    end
  end

  // stage 2 output registers; match is already gated by valid so misses read as zero
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid    <= 1'b0;
      region_id    <= '0;
      read_address <= '0;
    end else begin
      out_valid    <= s1_valid;
      region_id    <= id_c;
      read_address <= addr_c;
    end
  end

endmodule

// File: tb/tb_bg_region_map.sv
// tb_bg_region_map: directed and random checks of bg_region_map against a behavioural model
module tb_bg_region_map;
  localparam int N = 4, CW = 10, AW = 19;

  logic Clk = 1'b0, Reset_n, pix_valid, cfg_we;
  logic [CW-1:0] DrawX, DrawY;
  logic [2:0] cfg_region, cfg_field;
  logic [AW-1:0] cfg_data;
  logic cfg_ack, cfg_err, out_valid;
  logic [2:0] region_id;
  logic [AW-1:0] read_address;

  bg_region_map #(.NUM_REGIONS(N), .COORD_W(CW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .out_valid(out_valid), .region_id(region_id),
    .read_address(read_address)
  );

  always #5 Clk = ~Clk;

  typedef struct {bit v; int id; int addr;} exp_t;

  int m_x0[N], m_y0[N], m_w[N], m_h[N], m_base[N];
  bit m_en[N];
  exp_t p1, p2;
  int compared = 0, mismatched = 0;
  string lbl = "reset";

  task automatic model_reset();
    m_x0 = '{0, 320, 320, 0};
    m_y0 = '{0, 0, 240, 0};
    m_w  = '{320, 320, 320, 0};
    m_h  = '{480, 240, 240, 0};
    m_base = '{0, 0, 0, 0};
    m_en = '{1, 1, 1, 0};
    p1 = '{0, 0, 0};
    p2 = '{0, 0, 0};
  endtask

  function automatic exp_t predict(bit v, int x, int y);
    if (!v) return '{0, 0, 0};
    for (int k = 0; k < N; k++)
      if (m_en[k] && x >= m_x0[k] && x < m_x0[k] + m_w[k] && y >= m_y0[k] && y < m_y0[k] + m_h[k])
        return '{1, k + 1, (m_base[k] + (x - m_x0[k]) + (y - m_y0[k]) * m_w[k]) & ((1 << AW) - 1)};
    return '{1, 0, 0};
  endfunction

  function automatic bit legal(int r, int f);
    return r < N && f <= 5;
  endfunction

  task automatic model_write(int r, int f, int d);
    if (!legal(r, f)) return;
    if (f == 0) m_x0[r] = d & ((1 << CW) - 1);
    if (f == 1) m_y0[r] = d & ((1 << CW) - 1);
    if (f == 2) m_w[r] = d & ((1 << CW) - 1);
    if (f == 3) m_h[r] = d & ((1 << CW) - 1);
    if (f == 4) m_base[r] = d & ((1 << AW) - 1);
    if (f == 5) m_en[r] = d[0];
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s/%s observed=%0d expected=%0d", lbl, tag, obs, exp);
    end
  endtask

  task automatic check_outputs(exp_t e, bit ea, bit ee);
    check("out_valid", 32'(out_valid), 32'(e.v));
    check("region_id", 32'(region_id), e.id);
    check("read_address", 32'(read_address), e.addr);
    check("cfg_ack", 32'(cfg_ack), 32'(ea));
    check("cfg_err", 32'(cfg_err), 32'(ee));
  endtask

  task automatic step(bit v, int x, int y, bit we = 0, int r = 0, int f = 0, int d = 0);
    exp_t e;
    bit ea, ee;
    pix_valid = v; DrawX = CW'(x); DrawY = CW'(y);
    cfg_we = we; cfg_region = 3'(r); cfg_field = 3'(f); cfg_data = AW'(d);
    e = predict(v, x, y);
    ea = we && legal(r, f);
    ee = we && !legal(r, f);
    if (we) model_write(r, f, d);
    @(posedge Clk); #1;
    p2 = p1; p1 = e;
    check_outputs(p2, ea, ee);
  endtask

  task automatic flush();
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    Reset_n = 1'b0; pix_valid = 1'b0; cfg_we = 1'b0; DrawX = '0; DrawY = '0;
    cfg_region = '0; cfg_field = '0; cfg_data = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_outputs('{0, 0, 0}, 0, 0);
    Reset_n = 1'b1;

    lbl = "defaults";
    step(1, 0, 0); step(1, 319, 479); step(1, 320, 0); step(1, 639, 239); step(1, 320, 240);
    flush();

    lbl = "bounds";
    step(1, 320, 480); step(1, 639, 480); step(1, 640, 0); step(1, 0, 480); step(1, 1023, 1023);
    flush();

    lbl = "priority";
    step(0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 3, 1, 0);
    step(0, 0, 0, 1, 3, 2, 16);
    step(1, 5, 5, 1, 3, 3, 16);
    step(1, 5, 5, 1, 3, 4, 1000);
    step(1, 5, 5, 1, 3, 5, 1);
    step(1, 5, 5, 1, 0, 5, 0);
    step(1, 5, 5);
    step(1, 16, 5);
    step(1, 5, 16);
    flush();

    lbl = "cfg_timing";
    step(1, 330, 10, 1, 1, 0, 400);
    step(1, 330, 10);
    step(1, 400, 10);
    flush();

    lbl = "cfg_error";
    step(1, 400, 10, 1, 1, 6, 0);
    step(1, 400, 10, 1, 5, 0, 0);
    step(1, 400, 10, 1, 0, 7, 1);
    step(1, 100, 100);
    flush();

    lbl = "midreset";
    step(1, 10, 10);
    step(1, 320, 240);
    pix_valid = 1'b1; DrawX = CW'(330); DrawY = CW'(10);
    Reset_n = 1'b0;
    #1;
    check_outputs('{0, 0, 0}, 0, 0);
    @(posedge Clk); #1;
    check_outputs('{0, 0, 0}, 0, 0);
    pix_valid = 1'b0;
    Reset_n = 1'b1;
    model_reset();
    flush();
    lbl = "restored";
    step(1, 0, 0); step(1, 319, 479); step(1, 330, 10); step(1, 639, 239); step(1, 320, 240);
    flush();

    lbl = "random";
    for (int i = 0; i < 400; i++) begin
      bit we;
      int r, f, d;
      we = ($urandom_range(0, 5) == 0);
      r = (i % 3 == 0) ? $urandom_range(0, 7) : $urandom_range(0, N - 1);
      f = $urandom_range(0, 6);
      d = (f == 4) ? int'($urandom_range(0, (1 << AW) - 1)) :
          (f == 5) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 700));
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 700), $urandom_range(0, 520), we, r, f, d);
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
